usb_rx_bit_decoder: RTL and testbench

Receive-side bit layer of the USB full-speed endpoint. It sits directly upstream of the RX control FSM. It synchronises raw D+/D−, recovers bit timing from line edges, NRZI-decodes, removes stuffed bits and assembles bytes. It supplies `edge_detect`, `eop`, `shift_enable`, `rcv_data` and `byte_received` to the FSM, which supplies `enable_timer` back.

---
 rtl/usb_rx_if.sv | 22 ++
 rtl/usb_rx_bit_decoder.sv | 102 ++++++++++
 tb/tb_usb_rx_bit_decoder.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_if.sv
// Line-side and RX-FSM-side signals of the USB full-speed receive bit layer.
interface usb_rx_if;
  logic       d_plus;
  logic       d_minus;
  logic       enable_timer;
  logic       edge_detect;
  logic       eop;
  logic       shift_enable;
  logic [7:0] rcv_data;
  logic       byte_received;
  logic       stuff_err;

  modport master (
    output d_plus, d_minus, enable_timer,
    input  edge_detect, eop, shift_enable, rcv_data, byte_received, stuff_err
  );

  modport slave (
    input  d_plus, d_minus, enable_timer,
    output edge_detect, eop, shift_enable, rcv_data, byte_received, stuff_err
  );
endinterface

// File: rtl/usb_rx_bit_decoder.sv
// USB FS receive bit layer: sync, edge resync timer, NRZI decode, unstuff, byte assembly.
// Optional stuffed-bit value check enabled by defining USB_RX_STUFF_ERR_EN.
module usb_rx_bit_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PHASE = 3
) (
  input  logic   clk,
  input  logic   n_rst,
  usb_rx_if.slave bus
);
  localparam int TW = $clog2(CLKS_PER_BIT);

  logic          dp_meta, dp_s, dm_meta, dm_s, dp_last;
  logic          edge_q, eop_q, byte_q;
  logic [TW-1:0] tcnt, tcnt_cur;
  logic          shift_en, dec_bit, is_stuff, nrzi_prev;
  logic [2:0]    ones, bcnt;
  logic [7:0]    rcv_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_meta <= 1'b1;
      dp_s    <= 1'b1;
      dm_meta <= 1'b0;
      dm_s    <= 1'b0;
      dp_last <= 1'b1;
      edge_q  <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      dp_meta <= bus.d_plus;
      dp_s    <= dp_meta;
      dm_meta <= bus.d_minus;
      dm_s    <= dm_meta;
      dp_last <= dp_s;
      edge_q  <= (dp_s != dp_last);
      eop_q   <= !dp_s && !dm_s;
    end
  end

  // Resync takes effect in the edge cycle itself, so a coincident sample point is suppressed.
  assign tcnt_cur = edge_q ? '0 : tcnt;
  assign shift_en = bus.enable_timer && (tcnt_cur == TW'(SAMPLE_PHASE));
  assign dec_bit  = (dp_s == nrzi_prev);
  assign is_stuff = (ones == 3'd6);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                 tcnt <= '0;
    else if (!bus.enable_timer) tcnt <= '0;
    else                        tcnt <= tcnt_cur + TW'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      nrzi_prev <= 1'b1;
      ones      <= 3'd0;
      bcnt      <= 3'd0;
      rcv_q     <= 8'h00;
      byte_q    <= 1'b0;
    end else begin
      byte_q <= 1'b0;
      if (!bus.enable_timer) begin
        nrzi_prev <= 1'b1;
        ones      <= 3'd0;
        bcnt      <= 3'd0;
      end else if (shift_en) begin
        if (eop_q) begin
          nrzi_prev <= 1'b1;
          ones      <= 3'd0;
          bcnt      <= 3'd0;
        end else begin
          nrzi_prev <= dp_s;
          if (is_stuff) begin
            ones <= 3'd0;
          end else begin
            ones   <= dec_bit ? ones + 3'd1 : 3'd0;
            rcv_q  <= {rcv_q[6:0], dec_bit};
            bcnt   <= bcnt + 3'd1;
            byte_q <= (bcnt == 3'd7);
          end
        end
      end
    end
  end

`ifdef USB_RX_STUFF_ERR_EN
  logic serr_q;
  // A stuffed bit must decode as 0; a 1 there means seven consecutive ones on the wire.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) serr_q <= 1'b0;
    else        serr_q <= shift_en && !eop_q && is_stuff && dec_bit;
  end
  assign bus.stuff_err = serr_q;
`else
  assign bus.stuff_err = 1'b0;
`endif

  assign bus.edge_detect   = edge_q;
  assign bus.eop           = eop_q;
  assign bus.shift_enable  = shift_en;
  assign bus.rcv_data      = rcv_q;
  assign bus.byte_received = byte_q;
endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Bench: packets built from bytes (stuff + NRZI + optional edge jitter), bytes compared on receipt.
module tb_usb_rx_bit_decoder;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  usb_rx_if rx();
  usb_rx_bit_decoder #(.CLKS_PER_BIT(8), .SAMPLE_PHASE(3)) dut (
    .clk(clk), .n_rst(n_rst), .bus(rx)
  );

  typedef struct { bit dp; bit dm; int dur; } seg_t;
  seg_t       segs[$];
  logic [7:0] tx_bytes[$], exp_bytes[$], got_bytes[$];
  int         got_cyc[$];
  int checks = 0, failures = 0;
  int ncyc, last_edge, serr_cnt, eop_cnt, edge_cnt, shift_cnt, phase_bad, drop_at;
  bit arm;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic clear_mon();
    got_bytes.delete(); got_cyc.delete();
    ncyc = 0; last_edge = -100; serr_cnt = 0; eop_cnt = 0;
    edge_cnt = 0; shift_cnt = 0; phase_bad = 0; drop_at = -1;
  endtask

  // One clock: observe at the falling edge, then act as the RX FSM for enable_timer.
  task automatic step();
    @(negedge clk);
    ncyc++;
    if (rx.byte_received) begin got_bytes.push_back(rx.rcv_data); got_cyc.push_back(ncyc); end
    if (rx.stuff_err) serr_cnt++;
    if (rx.eop) eop_cnt++;
    if (rx.edge_detect) begin edge_cnt++; last_edge = ncyc; end
    if (rx.shift_enable) begin
      shift_cnt++;
      if ((ncyc - last_edge) % 8 != 3) phase_bad++;
    end
    if (arm && rx.edge_detect) begin rx.enable_timer = 1'b1; arm = 1'b0; end
    if (rx.eop || ncyc == drop_at) rx.enable_timer = 1'b0;
  endtask

  // SYNC + tx_bytes, stuffed and NRZI coded, raw_ones unstuffed ones appended, then SE0 x2 and J.
  task automatic make_packet(input bit jit, input int raw_ones);
    bit raw[$], bits[$];
    int cp_t[$];
    bit cp_dp[$], cp_dm[$];
    int ones, j, lo, hi;
    bit lv, prev;
    for (int k = 0; k < 8; k++) raw.push_back(k == 7);
    foreach (tx_bytes[b]) for (int k = 0; k < 8; k++) raw.push_back(tx_bytes[b][k]);
    ones = 0;
    foreach (raw[i]) begin
      bits.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 6) begin bits.push_back(1'b0); ones = 0; end
    end
    repeat (raw_ones) bits.push_back(1'b1);
    exp_bytes.delete();
    exp_bytes.push_back(8'h01);
    foreach (tx_bytes[b]) exp_bytes.push_back(rev8(tx_bytes[b]));
    lv = 1'b1; prev = 1'b1;
    foreach (bits[i]) begin
      if (!bits[i]) lv = !lv;
      if (lv != prev) begin cp_t.push_back(8*i); cp_dp.push_back(lv); cp_dm.push_back(!lv); end
      prev = lv;
    end
    cp_t.push_back(8*bits.size());      cp_dp.push_back(1'b0); cp_dm.push_back(1'b0);
    cp_t.push_back(8*bits.size() + 16); cp_dp.push_back(1'b1); cp_dm.push_back(1'b0);
    j = 0;
    foreach (cp_t[k]) begin
      if (jit) begin
        lo = (j - 2 < -2) ? -2 : j - 2;
        hi = (j + 2 > 2) ? 2 : j + 2;
        j = lo + int'($urandom_range(0, hi - lo));
      end
      cp_t[k] = cp_t[k] + j;
    end
    segs.delete();
    segs.push_back('{1'b1, 1'b0, 20 + cp_t[0]});
    for (int k = 0; k < cp_t.size() - 1; k++)
      segs.push_back('{cp_dp[k], cp_dm[k], cp_t[k+1] - cp_t[k]});
    segs.push_back('{1'b1, 1'b0, 40});
  endtask

  task automatic send();
    rx.enable_timer = 1'b0;
    arm = 1'b1;
    foreach (segs[i]) begin
      rx.d_plus = segs[i].dp;
      rx.d_minus = segs[i].dm;
      repeat (segs[i].dur) step();
    end
    arm = 1'b0;
  endtask

  task automatic test_reset();
    rx.d_plus = 1'b1; rx.d_minus = 1'b0; rx.enable_timer = 1'b0; arm = 1'b0;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx.edge_detect, rx.eop, rx.shift_enable, rx.byte_received, rx.stuff_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_pulses: got %b want 00000", {rx.edge_detect, rx.eop, rx.shift_enable, rx.byte_received, rx.stuff_err});
    end
    checks++;
    if (rx.rcv_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", rx.rcv_data); end
    n_rst = 1'b1;
    clear_mon();
    repeat (40) step();
    checks++;
    if (edge_cnt + shift_cnt + got_bytes.size() != 0) begin
      failures++; $display("FAIL reset_idle: got %0d pulses want 0", edge_cnt + shift_cnt + got_bytes.size());
    end
  endtask

  task automatic test_latency();
    int n;
    rx.enable_timer = 1'b0;
    rx.d_plus = 1'b0; rx.d_minus = 1'b1;
    n = 0;
    do begin step(); n++; end while (!rx.edge_detect && n < 20);
    checks++;
    if (n != 3) begin failures++; $display("FAIL edge_latency: got %0d want 3", n); end
    rx.d_minus = 1'b0;
    n = 0;
    do begin step(); n++; end while (!rx.eop && n < 20);
    checks++;
    if (n != 3) begin failures++; $display("FAIL eop_latency: got %0d want 3", n); end
    rx.d_plus = 1'b1; rx.d_minus = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_sync();
    tx_bytes.delete();
    make_packet(1'b0, 0); clear_mon(); send();
    checks++;
    if (got_bytes.size() != 1) begin failures++; $display("FAIL sync_count: got %0d want 1", got_bytes.size()); end
    else begin
      checks++;
      if (got_bytes[0] !== 8'h01) begin failures++; $display("FAIL sync_byte: got %h want 01", got_bytes[0]); end
    end
    checks++;
    if (phase_bad != 0) begin failures++; $display("FAIL sync_phase: got %0d bad samples want 0", phase_bad); end
  endtask

  task automatic test_pid();
    tx_bytes = '{8'hC3};
    make_packet(1'b0, 0); clear_mon(); send();
    checks++;
    if (got_bytes.size() != 2) begin failures++; $display("FAIL pid_count: got %0d want 2", got_bytes.size()); end
    else begin
      checks++;
      if (got_bytes[1][7:4] !== 4'b1100) begin failures++; $display("FAIL pid_nibble: got %b want 1100", got_bytes[1][7:4]); end
    end
  endtask

  task automatic test_unstuff();
    tx_bytes = '{8'hFF, 8'h00};
    make_packet(1'b0, 0); clear_mon(); send();
    checks++;
    if (got_bytes.size() != 3) begin failures++; $display("FAIL unstuff_count: got %0d want 3", got_bytes.size()); end
    else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (got_bytes[i] !== exp_bytes[i]) begin failures++; $display("FAIL unstuff_byte%0d: got %h want %h", i, got_bytes[i], exp_bytes[i]); end
      end
      checks++;
      if (got_cyc[2] - got_cyc[0] != 136) begin failures++; $display("FAIL unstuff_gap: got %0d want 136", got_cyc[2] - got_cyc[0]); end
    end
    checks++;
    if (serr_cnt != 0) begin failures++; $display("FAIL unstuff_err: got %0d want 0", serr_cnt); end
  endtask

  task automatic test_jitter();
    tx_bytes = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    make_packet(1'b1, 0); clear_mon(); send();
    checks++;
    if (got_bytes.size() != exp_bytes.size()) begin
      failures++; $display("FAIL jitter_count: got %0d want %0d", got_bytes.size(), exp_bytes.size());
    end else begin
      foreach (exp_bytes[i]) begin
        checks++;
        if (got_bytes[i] !== exp_bytes[i]) begin failures++; $display("FAIL jitter_byte%0d: got %h want %h", i, got_bytes[i], exp_bytes[i]); end
      end
    end
    checks++;
    if (phase_bad != 0) begin failures++; $display("FAIL jitter_phase: got %0d bad samples want 0", phase_bad); end
  endtask

  task automatic test_eop_stuff();
    int exp_serr;
`ifdef USB_RX_STUFF_ERR_EN
    exp_serr = 1;
`else
    exp_serr = 0;
`endif
    tx_bytes.delete();
    make_packet(1'b0, 7); clear_mon(); send();
    checks++;
    if (serr_cnt != exp_serr) begin failures++; $display("FAIL stuff_err_count: got %0d want %0d", serr_cnt, exp_serr); end
    checks++;
    if (eop_cnt != 16) begin failures++; $display("FAIL eop_width: got %0d want 16", eop_cnt); end
    checks++;
    if (got_bytes.size() != 1) begin failures++; $display("FAIL partial_byte: got %0d bytes want 1", got_bytes.size()); end
    tx_bytes = '{8'h96};
    make_packet(1'b0, 0); clear_mon(); send();
    checks++;
    if (got_bytes.size() != 2 || got_bytes[1] !== rev8(8'h96)) begin
      failures++; $display("FAIL after_eop: got %0d bytes want 2 with %h", got_bytes.size(), rev8(8'h96));
    end
  endtask

  task automatic test_enable_drop();
    tx_bytes = '{8'hA5};
    make_packet(1'b0, 0); clear_mon();
    drop_at = 20 + 8*12;
    send();
    checks++;
    if (got_bytes.size() != 1) begin failures++; $display("FAIL drop_count: got %0d want 1", got_bytes.size()); end
    tx_bytes = '{8'h3A};
    make_packet(1'b0, 0); clear_mon(); send();
    checks++;
    if (got_bytes.size() != 2 || got_bytes[1] !== rev8(8'h3A)) begin
      failures++; $display("FAIL drop_recover: got %0d bytes want 2 with %h", got_bytes.size(), rev8(8'h3A));
    end
  endtask

  task automatic test_reset_mid();
    tx_bytes = '{8'h5A};
    make_packet(1'b0, 0); clear_mon(); send();
    rx.d_plus = 1'b0; rx.d_minus = 1'b1; rx.enable_timer = 1'b1;
    repeat (5) step();
    n_rst = 1'b0;
    #1;
    checks++;
    if (rx.rcv_data !== 8'h00 || {rx.edge_detect, rx.eop, rx.shift_enable, rx.byte_received, rx.stuff_err} !== 5'b0) begin
      failures++; $display("FAIL reset_mid: got data %h flags %b want 00 00000", rx.rcv_data,
        {rx.edge_detect, rx.eop, rx.shift_enable, rx.byte_received, rx.stuff_err});
    end
    rx.d_plus = 1'b1; rx.d_minus = 1'b0; rx.enable_timer = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    clear_mon();
    repeat (40) step();
    checks++;
    if (edge_cnt + shift_cnt + got_bytes.size() != 0) begin
      failures++; $display("FAIL reset_mid_idle: got %0d pulses want 0", edge_cnt + shift_cnt + got_bytes.size());
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, 4));
      tx_bytes.delete();
      repeat (n) tx_bytes.push_back(8'($urandom_range(0, 255)));
      make_packet(1'($urandom_range(0, 1)), 0); clear_mon(); send();
      checks++;
      if (got_bytes.size() != exp_bytes.size()) begin
        failures++; $display("FAIL rand%0d_count: got %0d want %0d", it, got_bytes.size(), exp_bytes.size());
      end else begin
        foreach (exp_bytes[i]) begin
          checks++;
          if (got_bytes[i] !== exp_bytes[i]) begin failures++; $display("FAIL rand%0d_byte%0d: got %h want %h", it, i, got_bytes[i], exp_bytes[i]); end
        end
      end
      checks++;
      if (serr_cnt != 0) begin failures++; $display("FAIL rand%0d_err: got %0d want 0", it, serr_cnt); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_latency();
    test_sync();
    test_pid();
    test_unstuff();
    test_jitter();
    test_eop_stuff();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
